bip_mem_copier: RTL
===================

Name: bip_mem_copier

Overview:
- Bus-initiator block that drives the Rd/Wr/address/data side of the BIP DataMemory.
- It is the requesting end of the same interface the memory responds on.
- On a start pulse it copies a block of 16-bit words from a source address range to a destination range, one read and one write per word.
- It sits beside the CPU as a simple block-move engine (memory init, stack/array moves) and reports busy/done.

Parameters:
- ADDR_W, 11, address width; matches the DataMemory address bus (2048 words).
- DATA_W, 16, data word width.
- RD_LAT, 1, cycles from the mem_rd assertion cycle to valid mem_rdata; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  stop request; sampled in any busy state.
- src_addr  in  ADDR_W  first source word address; latched on accepted start.
- dst_addr  in  ADDR_W  first destination word address; latched on accepted start.
- length  in  ADDR_W+1  number of words to copy (0..2048); latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE state.
- done  out  1  one-cycle pulse in DONE.
- aborted  out  1  valid with done; high if the copy ended by abort.
- mem_rd  out  1  read strobe to DataMemory (its Rd).
- mem_wr  out  1  write strobe to DataMemory (its Wr).
- mem_addr  out  ADDR_W  address to DataMemory.
- mem_wdata  out  DATA_W  write data to DataMemory (its In_Data).
- mem_rdata  in  DATA_W  read data from DataMemory (its Out_Data).

Behaviour:
- Reset (async): state IDLE; busy, done, aborted, mem_rd, mem_wr = 0; mem_addr, mem_wdata = 0; internal counters = 0.
- Reset mid-operation takes effect immediately. A strobe in flight is dropped and no partial write occurs after reset asserts.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - On start=1, latch src, dst and len.
  - If len==0, go to DONE; otherwise go to READ.
  - start while not in IDLE is ignored, and no queueing occurs.
- READ: mem_rd=1 and mem_addr=src for exactly one cycle; go to WAIT.
- WAIT:
  - Lasts RD_LAT cycles, counted with a wait counter.
  - mem_rd=0 and mem_wr=0 throughout.
  - mem_rdata is captured into the data register on the edge ending the last WAIT cycle; then go to WRITE.
- WRITE:
  - mem_wr=1, mem_addr=dst, mem_wdata=captured word, for exactly one cycle.
  - Then src+=1, dst+=1, remaining-=1.
  - If the new remaining==0, go to DONE; otherwise go to READ.
- DONE: done=1 for one cycle; busy still 1; then IDLE with busy=0.
- Throughput: 2+RD_LAT cycles per word. With RD_LAT=1 a word costs 3 cycles, and N words finish with done in cycle 3N+1 after start.
- mem_rd and mem_wr are never high in the same cycle.
- Address arithmetic is modulo 2^ADDR_W, so 2047+1 wraps to 0 silently.
- Overlapping ranges are copied in ascending order with no overlap correction.
- abort:
  - If seen in READ or WAIT, the current word is not written; go to DONE with aborted=1.
  - If seen in WRITE, that write completes; go to DONE with aborted=1.
  - abort with start in IDLE: start wins and abort is ignored.
- aborted stays valid until the next accepted start, which clears it.
- mem_addr and mem_wdata hold their last values when strobes are low.

Optional Feature:
- Macro: BIP_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum [DATA_W-1:0]: the modulo-2^16 sum of all words written in the current copy.
  - checksum is cleared on accepted start and updated on each WRITE.
  - It is valid and stable from done until the next accepted start; reset value is 0.
- When undefined: the port and adder do not exist, and behaviour is otherwise identical.

Test Plan:
- Preload mem[53]=123, mem[54]=456, mem[55]=789; start with src=53, dst=100, len=3, RD_LAT=1 -> three Rd/Wr pairs; mem[100..102]=123,456,789; done pulses in cycle 10 after start; aborted=0; checksum=1368 when enabled.
- len=0 with start -> no mem_rd or mem_wr; done one cycle after start; busy high for exactly that one cycle.
- src=2046, dst=0, len=4 -> reads from 2046, 2047, 0, 1; the wrap is exercised; writes go to 0..3, and mem[0] is overwritten before it is read as source (ascending order is required).
- abort asserted in the second WAIT of a 5-word copy -> exactly 1 write occurs; done with aborted=1; a following start clears aborted.
- Assert rst during the WRITE of word 2 -> mem_wr drops immediately; all outputs return to 0; a fresh start then copies correctly.
- RD_LAT=3 with a 2-word copy -> 5 cycles per word; mem_rdata sampled exactly 3 cycles after mem_rd; start pulsed while busy has no effect.

Source files
------------

// File: rtl/bip_mem_if.sv
// Request/response bus between a bus initiator and the BIP DataMemory
// (Rd, Wr, address, In_Data, Out_Data).
interface bip_mem_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/bip_mem_copier.sv
// Block-move engine for the BIP DataMemory: one read and one write per word.
// Optional running checksum of written words under `BIP_COPY_CHECKSUM_EN.
module bip_mem_copier #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              aborted,
`ifdef BIP_COPY_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    bip_mem_if.master         bus
);

    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   remaining;
    logic [WC_W-1:0]   wait_cnt;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              wait_last;
`ifdef BIP_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
`endif

    assign wait_last = (wait_cnt == WC_W'(RD_LAT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (length == '0) ? DONE : READ;
            READ:    state_next = abort ? DONE : WAIT;
            WAIT: begin
                if (abort)          state_next = DONE;
                else if (wait_last) state_next = WRITE;
            end
            WRITE:   state_next = (abort || remaining == (ADDR_W+1)'(1)) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so an async reset
    // drops them in the same instant; address/data are held registers.
    assign bus.mem_rd    = (state == READ);
    assign bus.mem_wr    = (state == WRITE);
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = data;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
`ifdef BIP_COPY_CHECKSUM_EN
    assign checksum      = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            data      <= '0;
            addr      <= '0;
            aborted   <= 1'b0;
`ifdef BIP_COPY_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        src       <= src_addr;
                        dst       <= dst_addr;
                        remaining <= length;
                        aborted   <= 1'b0;
`ifdef BIP_COPY_CHECKSUM_EN
                        sum       <= '0;
`endif
                        if (state_next == READ) addr <= src_addr;
                    end
                end
                READ: begin
                    wait_cnt <= '0;
                    if (abort) aborted <= 1'b1;
                end
                WAIT: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (wait_last) begin
                        data <= bus.mem_rdata;
                        addr <= dst;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                WRITE: begin
                    src       <= src + ADDR_W'(1);
                    dst       <= dst + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
`ifdef BIP_COPY_CHECKSUM_EN
                    sum       <= sum + data;
`endif
                    if (abort) aborted <= 1'b1;
                    if (state_next == READ) addr <= src + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
